mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage: takes EX/MEM outputs and performs data-memory loads/stores on an internal byte-enabled RAM.
//  Drives the MEM/WB register inputs: read data, ALU address, regwrite, MemtoReg and destination register.
//  Multi-cycle memory latency is absorbed by an FSM that asserts stall_out to the hazard unit and issues bubbles downstream.
// PARAMETERS
//  DEPTH        256  data RAM size in 32-bit words (power of 2); ADDR_W = $clog2(DEPTH)
//  WAIT_CYCLES  1    extra access cycles per load/store, legal 0..15
// PORTS
//  clk               in   1   clock, all state updates on posedge
//  reset             in   1   synchronous, active-high
//  valid_in          in   1   EX/MEM slot holds a real instruction
//  MemRead_in        in   1   load
//  MemWrite_in       in   1   store (MemRead_in & MemWrite_in never both set)
//  regwrite_in       in   1   WB control, forwarded
//  MemtoReg_in       in   1   WB control, forwarded
//  size_in           in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  unsigned_in       in   1   load zero-extends when 1, sign-extends when 0
//  alu_result_in     in   32  effective byte address / ALU result
//  write_data_in     in   32  store data (low bytes used for byte/half)
//  write_reg_addr_in in   5   destination register
//  read_data_out     out  32  extended load data; 0 for non-loads
//  address_out       out  32  ALU result / address to MEM/WB
//  regwrite_out      out  1   0 whenever stall_out=1 (bubble)
//  MemtoReg_out      out  1
//  write_reg_addr_out out 5
//  stall_out         out  1   hold IF..EX/MEM stages this cycle
//  misalign_out      out  1   misaligned access flag (tied 0 without macro)
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, request/rdata regs=0; all outputs 0. RAM contents NOT cleared.
//  States: IDLE, BUSY, DONE (from package).
//  IDLE, no mem op (valid_in=0 or no MemRead/MemWrite): combinational pass-through, stall_out=0,
//   address_out=alu_result_in, regwrite_out=regwrite_in&valid_in, read_data_out=0, state stays IDLE.
//  IDLE, valid mem op: stall_out=1, outputs bubble (regwrite_out=0); latch all inputs; counter<=WAIT_CYCLES; ->BUSY.
//  BUSY: stall_out=1, bubble; counter!=0 -> decrement; counter==0 -> access at this edge, ->DONE.
//   Store: write RAM word addr[ADDR_W+1:2] with byte enables: byte addr[1:0], half addr[1], word all 4.
//   Load: register selected byte/half/word, sign/zero-extended per unsigned_in; little-endian.
//  DONE: stall_out=0; outputs from latched request (read_data_out=rdata, 0 for stores); ->IDLE unconditionally.
//  Latency: mem op presented cycle 0, stall_out high cycles 0..WAIT_CYCLES+1, result valid cycle WAIT_CYCLES+2.
//  Addresses beyond DEPTH wrap modulo DEPTH words (upper bits ignored).
//  Inputs ignored while BUSY/DONE (upstream is held by stall_out).
//  Reset mid-operation: aborts; a store not yet at its access edge is never written; -> IDLE.
//  Reserved size 11 behaves exactly as word.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is misaligned;
//   request still sequenced through BUSY/DONE, but no RAM write, read_data_out=0, regwrite_out=0,
//   misalign_out=1 in DONE cycle only.
//  Undefined: misalign_out=0; half ignores addr[0], word ignores addr[1:0] (forced alignment).
// STRUCTURE
//  mem_access_stage_pkg: state enum, size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), CNT_W=4.
//  Sub-module dmem_ram: DEPTH x 32 sync-write RAM with 4-bit byte enable and registered read port.
//  Top holds FSM, counter, request latch, byte-lane steering and load extension.
// TESTING
//  Reset held 2 cycles -> all outputs 0, stall_out=0, state IDLE.
//  ALU op addr 0x44, regwrite=1, no mem -> same cycle address_out=0x44, regwrite_out=1, stall_out=0.
//  SW 0xDEADBEEF @0x10 then LW @0x10, WAIT_CYCLES=1 -> stall 3 cycles each, LW DONE read_data_out=0xDEADBEEF.
//  SB 0x80 @0x13; LB @0x13 -> 0xFFFFFF80; LBU -> 0x00000080; SH 0x8001 @0x12; LH -> 0xFFFF8001.
//  Reset asserted in BUSY (counter!=0) of SW 0x12345678 @0x20 -> LW @0x20 returns prior contents.
//  LW @0x11: macro on -> misalign_out=1, regwrite_out=0, data 0; macro off -> returns word @0x10.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage: FSM states, access sizes, request record and load extension.
package mem_access_stage_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef struct packed {
      logic        load;
      logic        store;
      logic        regwrite;
      logic        memtoreg;
      logic [1:0]  size;
      logic        unsgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } req_t;

   // Pick the addressed lane out of a little-endian word and extend it; size 11 acts as word.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic unsgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: return unsgn ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_HALF: return unsgn ? {16'h0, h} : {{16{h[15]}}, h};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 data RAM: synchronous byte-enabled write, registered read port.
module dmem_ram #(
   parameter int unsigned DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [3:0]               be,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   input  logic                     re,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: multi-cycle loads/stores on an internal RAM, stalling upstream while busy.
// Optional MEM_MISALIGN_TRAP_EN flags misaligned half/word accesses instead of forcing alignment.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        regwrite_in,
   input  logic        MemtoReg_in,
   input  logic [1:0]  size_in,
   input  logic        unsigned_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] write_data_in,
   input  logic [4:0]  write_reg_addr_in,
   output logic [31:0] read_data_out,
   output logic [31:0] address_out,
   output logic        regwrite_out,
   output logic        MemtoReg_out,
   output logic [4:0]  write_reg_addr_out,
   output logic        stall_out,
   output logic        misalign_out
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   req_t              req;
   logic              mem_op;
   logic              access;
   logic              misalign;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic [31:0]       ram_q;
   logic [31:0]       load_val;

   assign mem_op = valid_in & (MemRead_in | MemWrite_in);
   assign access = (state == BUSY) && (cnt == '0) && !reset;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign = ((req.size == SZ_HALF) && req.addr[0]) ||
                     (req.size[1] && (req.addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // Byte-lane steering for stores; size 11 is treated as a word.
   always_comb begin
      be    = 4'b1111;
      wdata = req.wdata;
      case (req.size)
         SZ_BYTE: begin
            be    = 4'b0001 << req.addr[1:0];
            wdata = {4{req.wdata[7:0]}};
         end
         SZ_HALF: begin
            be    = req.addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{req.wdata[15:0]}};
         end
         default: ;
      endcase
   end

   dmem_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (access & req.store & !misalign),
      .be    (be),
      .addr  (req.addr[ADDR_W+1:2]),
      .wdata (wdata),
      .re    (access & req.load & !misalign),
      .rdata (ram_q)
   );

   assign load_val = load_extend(ram_q, req.addr[1:0], req.size, req.unsgn);

   // Sequencer: latch the request, count wait cycles, access on the last BUSY edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         req   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op) begin
                  req <= '{load: MemRead_in, store: MemWrite_in, regwrite: regwrite_in,
                           memtoreg: MemtoReg_in, size: size_in, unsgn: unsigned_in,
                           addr: alu_result_in, wdata: write_data_in, rd: write_reg_addr_in};
                  cnt   <= CNT_W'(WAIT_CYCLES);
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               else           state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output mux: pass-through when idle, bubble while stalled, latched result when done.
   always_comb begin
      read_data_out      = '0;
      address_out        = '0;
      regwrite_out       = 1'b0;
      MemtoReg_out       = 1'b0;
      write_reg_addr_out = '0;
      stall_out          = 1'b0;
      misalign_out       = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (mem_op) begin
                  stall_out = 1'b1;
               end else begin
                  address_out        = alu_result_in;
                  regwrite_out       = regwrite_in & valid_in;
                  MemtoReg_out       = MemtoReg_in;
                  write_reg_addr_out = write_reg_addr_in;
               end
            end
            BUSY: stall_out = 1'b1;
            default: begin
               address_out        = req.addr;
               MemtoReg_out       = req.memtoreg;
               write_reg_addr_out = req.rd;
               misalign_out       = misalign;
               regwrite_out       = req.regwrite & !misalign;
               read_data_out      = (req.load && !misalign) ? load_val : '0;
            end
         endcase
      end
   end

endmodule
